// File: rtl/wisc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wisc_pkg                                                  |
// | Desc     : Shared fetch-side definitions for the WISC pipeline:      |
// |            condition codes, flag bit positions, fetch FSM states     |
// |            and default PC parameters.                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package wisc_pkg;

  // Default address width, reset PC and sequential increment
  localparam int          WISC_ADDR_W   = 16;
  localparam logic [15:0] WISC_RESET_PC = 16'h0000;
  localparam logic [15:0] WISC_PC_INC   = 16'd2;

  // Bit positions inside the {Z,V,N} flags vector
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Branch condition codes
  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GE  = 3'b100;
  localparam logic [2:0] CC_LE  = 3'b101;
  localparam logic [2:0] CC_OV  = 3'b110;
  localparam logic [2:0] CC_UNC = 3'b111;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : branch_cond_eval                                          |
// | Desc     : Combinational evaluation of a branch condition code       |
// |            against the {Z,V,N} flags.                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module branch_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       cond_true_o
);

  logic w_z, w_v, w_n;

  assign w_z = flags_i[FLAG_Z];
  assign w_v = flags_i[FLAG_V];
  assign w_n = flags_i[FLAG_N];

  // Decode the condition code into a single taken/not-taken predicate
  always_comb begin
    cond_true_o = 1'b0;
    case (cond_i)
      CC_NE:   cond_true_o = ~w_z;
      CC_EQ:   cond_true_o = w_z;
      CC_GT:   cond_true_o = ~w_z & ~w_n;
      CC_LT:   cond_true_o = w_n;
      CC_GE:   cond_true_o = w_z | ~w_n;
      CC_LE:   cond_true_o = w_z | w_n;
      CC_OV:   cond_true_o = w_v;
      CC_UNC:  cond_true_o = 1'b1;
      default: cond_true_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_ctrl                                                |
// | Desc     : WISC instruction fetch sequencer. Owns the PC, drives the |
// |            imem request handshake, redirects on taken branches,      |
// |            buffers a word under back-end stall and stops on HLT.     |
// |            Optional: FETCH_PERF_CNT_EN adds stall/miss counters.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fetch_ctrl #(
  parameter int                ADDR_W   = wisc_pkg::WISC_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = wisc_pkg::WISC_RESET_PC,
  parameter logic [ADDR_W-1:0] PC_INC   = wisc_pkg::WISC_PC_INC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  input  logic [8:0]        br_imm,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic              br_reg,
  input  logic [ADDR_W-1:0] br_reg_tgt,
  input  logic [2:0]        flags,
  input  logic              halt,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_done,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              flush,
  output logic              halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       miss_cnt,
`endif
  output logic [ADDR_W-1:0] pc
);

  import wisc_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, ipc_q, ipc_d;
  logic [15:0]       instr_q, instr_d, hold_q, hold_d;
  logic              req_q, valid_q, valid_d, flush_q, halted_q, hpend_q, hpend_d;

  logic              w_cond_true, w_taken, w_outstanding;
  logic [ADDR_W-1:0] w_imm_ext, w_target, w_pc_next;

  branch_cond_eval u_cond (
    .cond_i      (br_cond),
    .flags_i     (flags),
    .cond_true_o (w_cond_true)
  );

  assign w_taken   = br_valid & w_cond_true;
  assign w_imm_ext = {{(ADDR_W-10){br_imm[8]}}, br_imm, 1'b0};
  assign w_target  = br_reg ? br_reg_tgt : (br_pc + PC_INC + w_imm_ext);
  assign w_pc_next = pc_q + PC_INC;
  // A request is in flight and will not complete this cycle
  assign w_outstanding = ((state_q == FETCH) || (state_q == DRAIN)) && !imem_done;

  // Next-state logic: redirect beats halt, halt beats normal sequencing
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    hpend_d = hpend_q;
    if (state_q == HALT) begin
      valid_d = 1'b0;
    end else if (w_taken) begin
      pc_d    = w_target;
      valid_d = 1'b0;
      hold_d  = '0;
      hpend_d = 1'b0;
      if (w_outstanding) begin
        state_d = DRAIN;
      end else begin
        state_d = FETCH;
        addr_d  = w_target;
      end
    end else if (halt) begin
      pc_d    = ipc_q + PC_INC;
      valid_d = 1'b0;
      hold_d  = '0;
      if (w_outstanding) begin
        state_d = DRAIN;
        hpend_d = 1'b1;
      end else begin
        state_d = HALT;
        hpend_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (imem_done) begin
            if (!stall) begin
              instr_d = imem_rdata;
              ipc_d   = addr_q;
              valid_d = 1'b1;
              pc_d    = w_pc_next;
              addr_d  = w_pc_next;
            end else begin
              hold_d  = imem_rdata;
              state_d = HOLD;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d = hold_q;
            ipc_d   = addr_q;
            valid_d = 1'b1;
            pc_d    = w_pc_next;
            addr_d  = w_pc_next;
            state_d = FETCH;
          end
        end
        DRAIN: begin
          if (imem_done) begin
            if (hpend_q) begin
              state_d = HALT;
            end else begin
              addr_d  = pc_q;
              state_d = FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; request/halted mirror the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      ipc_q    <= '0;
      instr_q  <= '0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      hpend_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      ipc_q    <= ipc_d;
      instr_q  <= instr_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      req_q    <= (state_d == FETCH) || (state_d == DRAIN);
      flush_q  <= w_taken && (state_q != HALT);
      halted_q <= (state_d == HALT);
      hpend_q  <= hpend_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = addr_q;
  assign imem_req    = req_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign flush       = flush_q;
  assign halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, miss_cnt_q;

  // Saturating counters: stalled cycles outside HALT, FETCH cycles with no completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      if (stall && (state_q != HALT) && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if ((state_q == FETCH) && !imem_done && (miss_cnt_q != 16'hFFFF))
        miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign miss_cnt  = miss_cnt_q;
`endif

endmodule
`default_nettype wire
